// File: rtl/shift_arbiter_ctrl_pkg.sv
// rtl/shift_arbiter_ctrl_pkg.sv - shared encodings and helpers for the shift arbiter controller
package shift_arbiter_ctrl_pkg;

   localparam logic [1:0] OP_SRL  = 2'b00;
   localparam logic [1:0] OP_SRA  = 2'b01;
   localparam logic [1:0] OP_SLL  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

   typedef enum logic {
      S_EMPTY = ST_EMPTY,
      S_FULL  = ST_FULL
   } state_t;

   function automatic logic [31:0] bitrev(input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = d[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/barrel_shifter_right.sv
// rtl/barrel_shifter_right.sv - 32-bit logical right barrel shifter, five log stages
module barrel_shifter_right (
   input  logic [31:0] data,
   input  logic [4:0]  amt,
   output logic [31:0] result
);

   logic [31:0] s1, s2, s3, s4;

   assign s1     = amt[0] ? {1'b0,  data[31:1]} : data;
   assign s2     = amt[1] ? {2'b0,  s1[31:2]}   : s1;
   assign s3     = amt[2] ? {4'b0,  s2[31:4]}   : s2;
   assign s4     = amt[3] ? {8'b0,  s3[31:8]}   : s3;
   assign result = amt[4] ? {16'b0, s4[31:16]}  : s4;

endmodule

// File: rtl/shift_arbiter_ctrl_shift_op_mapper.sv
// rtl/shift_arbiter_ctrl_shift_op_mapper.sv - maps SRL/SRA/SLL onto the right-only shifter
module shift_op_mapper
   import shift_arbiter_ctrl_pkg::*;
(
   input  logic [31:0] data,
   input  logic [4:0]  amt,
   input  logic [1:0]  op,
   output logic [31:0] result
);

   logic [31:0] sh_in;
   logic [31:0] sh_out;
   logic [31:0] fill;

   // Left shifts ride the right shifter by reversing bits on both sides.
   assign sh_in = (op == OP_SLL) ? bitrev(data) : data;

   barrel_shifter_right u_shifter (
      .data   (sh_in),
      .amt    (amt),
      .result (sh_out)
   );

   assign fill = data[31] ? ~(ALL_ONES >> amt) : 32'h0;

   always_comb begin
      result = data;
      case (op)
         OP_SRL:  result = sh_out;
         OP_SRA:  result = sh_out | fill;
         OP_SLL:  result = bitrev(sh_out);
         default: result = data;
      endcase
   end

endmodule

// File: rtl/shift_arbiter_ctrl.sv
// rtl/shift_arbiter_ctrl.sv - round-robin arbiter sharing one shifter, one-entry result stage
module shift_arbiter_ctrl
   import shift_arbiter_ctrl_pkg::*;
#(
   parameter int RR_INIT = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [31:0] req0_data,
   input  logic [4:0]  req0_amt,
   input  logic [1:0]  req0_op,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_data,
   input  logic [4:0]  req1_amt,
   input  logic [1:0]  req1_op,
   output logic        req1_ready,
   output logic        res_valid,
   output logic [31:0] res_data,
   output logic        res_id,
   input  logic        res_ready
);

   state_t      state, state_nxt;
   logic        rr_ptr;
   logic        grant;
   logic        can_accept;
   logic        accept;
   logic [31:0] sel_data;
   logic [4:0]  sel_amt;
   logic [1:0]  sel_op;
   logic [31:0] mapped;
   logic [31:0] res_data_q;
   logic        res_id_q;

   always_comb begin
      grant = rr_ptr;
      if (req0_valid && !req1_valid) begin
         grant = 1'b0;
      end else if (req1_valid && !req0_valid) begin
         grant = 1'b1;
      end
   end

   assign sel_data = grant ? req1_data : req0_data;
   assign sel_amt  = grant ? req1_amt  : req0_amt;
   assign sel_op   = grant ? req1_op   : req0_op;

   shift_op_mapper u_mapper (
      .data   (sel_data),
      .amt    (sel_amt),
      .op     (sel_op),
      .result (mapped)
   );

   // No handshake is offered while reset is asserted.
   always_comb begin
      state_nxt  = state;
      can_accept = !reset && ((state == S_EMPTY) || res_ready);
      req0_ready = can_accept && !grant;
      req1_ready = can_accept && grant;
      accept     = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
      case (state)
         S_EMPTY: if (accept) state_nxt = S_FULL;
         S_FULL: begin
            if (accept) begin
               state_nxt = S_FULL;
            end else if (res_ready) begin
               state_nxt = S_EMPTY;
            end
         end
         default: state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         res_data_q <= 32'h0;
         res_id_q   <= 1'b0;
         rr_ptr     <= 1'(RR_INIT);
      end else if (accept) begin
         res_data_q <= mapped;
         res_id_q   <= grant;
         rr_ptr     <= ~grant;
      end
   end

   assign res_valid = (state == S_FULL);
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// tb/tb_shift_arbiter_ctrl.sv - directed bench with a cycle-level reference model
module tb_shift_arbiter_ctrl;

   logic        clock;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_data, req1_data;
   logic [4:0]  req0_amt, req1_amt;
   logic [1:0]  req0_op, req1_op;
   logic        req0_ready, req1_ready;
   logic        res_valid;
   logic [31:0] res_data;
   logic        res_id;
   logic        res_ready;

   int n_cmp = 0;
   int n_bad = 0;

   shift_arbiter_ctrl #(.RR_INIT(0)) dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_amt   (req0_amt),
      .req0_op    (req0_op),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_amt   (req1_amt),
      .req1_op    (req1_op),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_id     (res_id),
      .res_ready  (res_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_shift(input logic [31:0] d, input logic [4:0] a,
                                               input logic [1:0] op);
      case (op)
         2'd0:    return d >> a;
         2'd1:    return $unsigned($signed(d) >>> a);
         2'd2:    return d << a;
         default: return d;
      endcase
   endfunction

   // Reference model: holding slot plus the requester favoured on a tie.
   logic        m_full = 1'b0;
   logic [31:0] m_data = 32'h0;
   logic        m_id   = 1'b0;
   logic        m_prio = 1'b0;
   logic        any_v, win, can, acc;

   always @(negedge clock) begin
      chk("res_valid", res_valid, m_full);
      chk("res_data", res_data, m_data);
      chk("res_id", res_id, m_id);
      any_v = req0_valid || req1_valid;
      win   = (req0_valid && !req1_valid) ? 1'b0 :
              (req1_valid && !req0_valid) ? 1'b1 : m_prio;
      can   = !reset && (!m_full || res_ready);
      if (any_v) begin
         chk("req0_ready", req0_ready, can && !win);
         chk("req1_ready", req1_ready, can && win);
      end
      acc = any_v && can;
      if (reset) begin
         m_full = 1'b0;
         m_data = 32'h0;
         m_id   = 1'b0;
         m_prio = 1'b0;
      end else if (acc) begin
         m_full = 1'b1;
         m_data = win ? model_shift(req1_data, req1_amt, req1_op)
                      : model_shift(req0_data, req0_amt, req0_op);
         m_id   = win;
         m_prio = !win;
      end else if (m_full && res_ready) begin
         m_full = 1'b0;
      end
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic set0(input logic v, input logic [31:0] d, input logic [4:0] a, input logic [1:0] o);
      req0_valid = v; req0_data = d; req0_amt = a; req0_op = o;
   endtask

   task automatic set1(input logic v, input logic [31:0] d, input logic [4:0] a, input logic [1:0] o);
      req1_valid = v; req1_data = d; req1_amt = a; req1_op = o;
   endtask

   initial begin
      reset = 1'b1;
      res_ready = 1'b1;
      set0(1'b0, 32'h0, 5'd0, 2'd0);
      set1(1'b0, 32'h0, 5'd0, 2'd0);
      repeat (2) step();
      reset = 1'b0;

      set0(1'b1, 32'h8000_00F0, 5'd4, 2'b01);
      @(negedge clock);
      chk("t1_reset_valid", res_valid, 1'b0);
      chk("t1_ready0", req0_ready, 1'b1);
      step();
      set0(1'b0, 32'h0, 5'd0, 2'd0);
      @(negedge clock);
      chk("t1_valid", res_valid, 1'b1);
      chk("t1_data", res_data, 32'hF800_000F);
      chk("t1_id", res_id, 1'b0);
      step();

      set1(1'b1, 32'h0000_0001, 5'd31, 2'b10);
      @(negedge clock);
      chk("t2_ready1", req1_ready, 1'b1);
      step();
      set1(1'b1, 32'h8000_0000, 5'd31, 2'b00);
      @(negedge clock);
      chk("t2_sll_data", res_data, 32'h8000_0000);
      chk("t2_sll_id", res_id, 1'b1);
      step();
      set1(1'b0, 32'h0, 5'd0, 2'd0);
      @(negedge clock);
      chk("t2_srl_data", res_data, 32'h0000_0001);
      step();

      set0(1'b1, 32'h1234_5678, 5'd4, 2'b00);
      set1(1'b1, 32'hF000_0000, 5'd8, 2'b01);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("t3_grant0", req0_ready, (i % 2) == 0);
         chk("t3_grant1", req1_ready, (i % 2) == 1);
         if (i > 0) chk("t3_res_id", res_id, ((i - 1) % 2) == 1);
         step();
      end

      res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("t4_hold_ready0", req0_ready, 1'b0);
         chk("t4_hold_ready1", req1_ready, 1'b0);
         chk("t4_hold_data", res_data, 32'hFFF0_0000);
         chk("t4_hold_id", res_id, 1'b1);
         step();
      end
      res_ready = 1'b1;
      @(negedge clock);
      chk("t4_release_ready0", req0_ready, 1'b1);
      step();
      set0(1'b0, 32'h0, 5'd0, 2'd0);
      set1(1'b0, 32'h0, 5'd0, 2'd0);
      @(negedge clock);
      chk("t4_next_id", res_id, 1'b0);
      chk("t4_next_data", res_data, 32'h0123_4567);
      step();

      for (int op = 0; op < 4; op++) begin
         set0(1'b1, 32'hDEAD_BEEF, 5'd0, 2'(op));
         @(negedge clock);
         chk("t5_ready0", req0_ready, 1'b1);
         if (op > 0) chk("t5_amt0_data", res_data, 32'hDEAD_BEEF);
         step();
      end
      set0(1'b0, 32'h0, 5'd0, 2'd0);
      @(negedge clock);
      chk("t5_amt0_last", res_data, 32'hDEAD_BEEF);
      step();

      res_ready = 1'b0;
      set0(1'b1, 32'h0000_FF00, 5'd8, 2'b00);
      step();
      set1(1'b1, 32'h0000_0080, 5'd3, 2'b10);
      @(negedge clock);
      chk("t6_full", res_valid, 1'b1);
      chk("t6_blocked0", req0_ready, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      res_ready = 1'b1;
      @(negedge clock);
      chk("t6_reset_valid", res_valid, 1'b0);
      chk("t6_rr_init0", req0_ready, 1'b1);
      chk("t6_rr_init1", req1_ready, 1'b0);
      step();
      set0(1'b0, 32'h0, 5'd0, 2'd0);
      set1(1'b0, 32'h0, 5'd0, 2'd0);
      @(negedge clock);
      chk("t6_after_valid", res_valid, 1'b1);
      chk("t6_after_id", res_id, 1'b0);
      chk("t6_after_data", res_data, 32'h0000_00FF);
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
